// File: rtl/lcd_char_controller.sv
// HD44780 2x16 character LCD driver: power-up wait, init sequence, then continuous
// refresh of both rows from a 32-byte Avalon-MM character buffer.
module lcd_char_controller #(
  parameter int unsigned POWERUP_CYCLES = 1000000,
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned EN_CYCLES      = 12,
  parameter int unsigned CMD_CYCLES     = 2500,
  parameter int unsigned CLEAR_CYCLES   = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic [7:0]  LCD_DATA,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic        LCD_EN,
  output logic        LCD_ON,
  output logic        frame_done
);
  localparam int CNT_W = 20;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [5:0] LAST_STEP = 6'd37;

  typedef enum logic [2:0] {S_POWERUP, S_IDLE, S_SETUP, S_PULSE, S_HOLD} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_step;
  logic             r_init_done;
  logic [15:0]      r_frame_cnt;
  logic [7:0]       r_buf [32];

  logic [4:0]  w_idx;
  logic [7:0]  w_byte;
  logic        w_rs;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign LCD_RW   = 1'b0;
  assign LCD_ON   = 1'b1;
  assign w_unused = ^writedata[31:8];

  // Steps 5..20 map to buffer 0..15, steps 22..37 to buffer 16..31
  assign w_idx = (r_step <= 6'd20) ? 5'(r_step - 6'd5) : 5'(r_step - 6'd6);

  // Byte and RS for the current sequencer step
  always_comb begin
    w_byte = 8'h20;
    w_rs   = 1'b1;
    if (r_step < 6'd4) begin
      w_rs = 1'b0;
      case (r_step[1:0])
        2'd0:    w_byte = 8'h38;
        2'd1:    w_byte = 8'h0C;
        2'd2:    w_byte = 8'h01;
        default: w_byte = 8'h06;
      endcase
    end else if (r_step == 6'd4) begin
      w_rs   = 1'b0;
      w_byte = 8'h80;
    end else if (r_step == 6'd21) begin
      w_rs   = 1'b0;
      w_byte = 8'hC0;
    end else begin
      w_byte = r_buf[w_idx];
    end
  end

  // Read mux
  always_comb begin
    w_rdata = 32'd0;
    if (!read) begin
      w_rdata = 32'd0;
    end else if (!address[5]) begin
      w_rdata = {24'd0, r_buf[address[4:0]]};
    end else if (address == 6'd32) begin
      w_rdata = {15'd0, r_init_done, r_frame_cnt};
    end else begin
      w_rdata = 32'd0;
    end
  end

  // Character buffer and registered read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) r_buf[i] <= 8'h20;
      readdata <= 32'd0;
    end else begin
      if (write && !address[5]) r_buf[address[4:0]] <= writedata[7:0];
      readdata <= w_rdata;
    end
  end

  // Sequencer and byte engine; bus byte is latched on IDLE->SETUP so buffer writes never disturb it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_POWERUP;
      r_cnt       <= CNT_W'(POWERUP_CYCLES - 1);
      r_step      <= 6'd0;
      r_init_done <= 1'b0;
      r_frame_cnt <= 16'd0;
      LCD_DATA    <= 8'h00;
      LCD_RS      <= 1'b0;
      LCD_EN      <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        S_POWERUP: begin
          if (r_cnt == '0) r_state <= S_IDLE;
          else             r_cnt   <= r_cnt - CNT_ONE;
        end
        S_IDLE: begin
          LCD_DATA <= w_byte;
          LCD_RS   <= w_rs;
          r_cnt    <= CNT_W'(SETUP_CYCLES - 1);
          r_state  <= S_SETUP;
        end
        S_SETUP: begin
          if (r_cnt == '0) begin
            LCD_EN  <= 1'b1;
            r_cnt   <= CNT_W'(EN_CYCLES - 1);
            r_state <= S_PULSE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_PULSE: begin
          if (r_cnt == '0) begin
            LCD_EN  <= 1'b0;
            r_cnt   <= (!LCD_RS && LCD_DATA == 8'h01) ? CNT_W'(CLEAR_CYCLES - 1)
                                                      : CNT_W'(CMD_CYCLES - 1);
            r_state <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            if (r_step == 6'd3) r_init_done <= 1'b1;
            if (r_step == LAST_STEP) begin
              r_step      <= 6'd4;
              frame_done  <= 1'b1;
              r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
              r_step <= r_step + 6'd1;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_state <= S_POWERUP;
          r_cnt   <= CNT_W'(POWERUP_CYCLES - 1);
          LCD_EN  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_char_controller.sv
// Directed bench for lcd_char_controller: expected LCD bytes and read data are queued
// when stimulus is set up and checked as the DUT strobes EN or returns readdata.
module tb_lcd_char_controller;
  localparam int P_SETUP   = 2;
  localparam int P_EN      = 3;
  localparam int P_CMD     = 5;
  localparam int P_CLEAR   = 8;
  localparam int P_POWERUP = 10;
  // EN-low span between pulses is the hold time plus one idle cycle plus the setup time
  localparam int OVH = 1 + P_SETUP;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  address = 6'd0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic [7:0]  LCD_DATA;
  logic        LCD_RS, LCD_RW, LCD_EN, LCD_ON, frame_done;

  lcd_char_controller #(
    .POWERUP_CYCLES(P_POWERUP), .SETUP_CYCLES(P_SETUP), .EN_CYCLES(P_EN),
    .CMD_CYCLES(P_CMD), .CLEAR_CYCLES(P_CLEAR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .write(write),
    .writedata(writedata), .read(read), .readdata(readdata),
    .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
    .LCD_ON(LCD_ON), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  logic [7:0]  img [32];
  int total = 0;
  int bad = 0;
  int n_popped = 0;
  int fd_cnt = 0;
  int low_cnt = 0;
  int high_cnt = 0;
  logic prev_en = 1'b0;
  logic prev_fd = 1'b0;
  bit push_first = 1'b1;
  bit push_prev_clear = 1'b0;
  exp_t mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] d);
    exp_t e;
    e.rs   = rs;
    e.data = d;
    e.gap  = push_first ? -1 : (push_prev_clear ? P_CLEAR + OVH : P_CMD + OVH);
    push_first      = 1'b0;
    push_prev_clear = (!rs && d == 8'h01);
    exp_q.push_back(e);
  endtask

  task automatic push_init();
    push_byte(1'b0, 8'h38);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h01);
    push_byte(1'b0, 8'h06);
  endtask

  task automatic push_frame();
    push_byte(1'b0, 8'h80);
    for (int i = 0; i < 16; i++) push_byte(1'b1, img[i]);
    push_byte(1'b0, 8'hC0);
    for (int i = 16; i < 32; i++) push_byte(1'b1, img[i]);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    address   = a;
    writedata = {24'hABCDEF, d};
    write     = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] e;
    @(negedge clk);
    address = a;
    read    = 1'b1;
    rd_q.push_back(exp);
    @(negedge clk);
    read = 1'b0;
    e = rd_q.pop_front();
    check(tag, readdata, e);
    @(negedge clk);
    check("rd_idle_zero", readdata, 32'd0);
  endtask

  // LCD bus monitor: checks each EN pulse against the expected-byte queue
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        low_cnt  = 0;
        high_cnt = 0;
        prev_en  = 1'b0;
        prev_fd  = 1'b0;
        n_popped = 0;
      end else begin
        if (LCD_EN && !prev_en) begin
          total++;
          assert (exp_q.size() > 0) else begin
            bad++;
            $error("FAIL unexpected_byte observed=%0h expected=none", LCD_DATA);
          end
          if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_popped++;
            check("bus_data", LCD_DATA, mon_e.data);
            check("bus_rs", LCD_RS, mon_e.rs);
            if (mon_e.gap < 0) check("powerup_wait", low_cnt >= P_POWERUP, 1);
            else               check("en_low_gap", low_cnt, mon_e.gap);
          end
          high_cnt = 1;
        end else if (LCD_EN) begin
          high_cnt++;
        end
        if (!LCD_EN && prev_en) begin
          check("en_high_len", high_cnt, P_EN);
          low_cnt = 1;
        end else if (!LCD_EN) begin
          low_cnt++;
        end
        if (frame_done) begin
          total++;
          assert (!prev_fd && !LCD_EN && n_popped > 4 && (n_popped - 4) % 34 == 0) else begin
            bad++;
            $error("FAIL frame_done_pos observed=%0d expected=4+34k", n_popped);
          end
          fd_cnt++;
        end
        prev_en = LCD_EN;
        prev_fd = frame_done;
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) img[i] = 8'h20;
    repeat (3) @(negedge clk);
    check("rst_en", LCD_EN, 1'b0);
    check("rst_data", LCD_DATA, 8'h00);
    check("rst_rs", LCD_RS, 1'b0);
    check("rst_readdata", readdata, 32'd0);
    check("rst_frame_done", frame_done, 1'b0);
    check("const_rw", LCD_RW, 1'b0);
    check("const_on", LCD_ON, 1'b1);

    img[0]  = 8'h41;
    img[31] = 8'h5A;
    push_init();
    push_frame();
    push_frame();
    img[5] = 8'h42;
    push_frame();

    #1 reset_n = 1'b1;
    wr(6'd0, 8'h41);
    wr(6'd31, 8'h5A);
    wr(6'd40, 8'hEE);
    rd("rd_addr0", 6'd0, 32'h41);
    rd("rd_addr31", 6'd31, 32'h5A);
    rd("rd_addr8", 6'd8, 32'h20);
    rd("rd_status_init", 6'd32, 32'h0);

    // Frame 2, char 5 is expected-queue entry 44
    for (int i = 0; i < 3000 && !(n_popped == 45 && LCD_EN); i++) @(negedge clk);
    check("wait_char5_pulse", (n_popped == 45 && LCD_EN), 1'b1);
    address   = 6'd5;
    writedata = 32'h42;
    write     = 1'b1;
    @(negedge clk);
    write = 1'b0;
    check("collide_bus_data", LCD_DATA, 8'h20);
    check("collide_bus_rs", LCD_RS, 1'b1);

    for (int i = 0; i < 3000 && fd_cnt < 2; i++) @(negedge clk);
    check("wait_two_frames", fd_cnt, 2);
    rd("rd_status_2frames", 6'd32, 32'h0001_0002);
    rd("rd_addr5_new", 6'd5, 32'h42);
    rd("rd_addr40", 6'd40, 32'h0);

    for (int i = 0; i < 3000 && !(fd_cnt == 3 && exp_q.size() == 0); i++) @(negedge clk);
    check("frame3_done", fd_cnt, 3);
    check("queue_drained", exp_q.size(), 0);

    // Reset in the middle of an EN pulse
    push_frame();
    for (int i = 0; i < 100 && !LCD_EN; i++) @(negedge clk);
    check("wait_pulse", LCD_EN, 1'b1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("async_en_drop", LCD_EN, 1'b0);
    check("async_data_clear", LCD_DATA, 8'h00);
    exp_q.delete();
    push_first      = 1'b1;
    push_prev_clear = 1'b0;
    push_init();
    push_byte(1'b0, 8'h80);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    rd("rd_after_rst0", 6'd0, 32'h20);
    rd("rd_after_rst5", 6'd5, 32'h20);
    rd("rd_after_rst31", 6'd31, 32'h20);
    rd("rd_status_rst", 6'd32, 32'h0);
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
    check("reinit_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
